// File: rtl/qracc_pkg.sv
// Shared types and helpers for the QRAcc layer scheduler.
package qracc_pkg;

  // Default widths used by the CSR-facing configuration record.
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    MAC_REQ  = 3'd2,
    MAC_WAIT = 3'd3,
    STORE    = 3'd4,
    DONE     = 3'd5
  } sched_state_e;

  // Plain-vector state encodings, kept bit-identical to the enum so that
  // legacy state decoders and debug taps keep working.
  localparam logic [2:0] S_IDLE     = IDLE;
  localparam logic [2:0] S_LOAD     = LOAD;
  localparam logic [2:0] S_MAC_REQ  = MAC_REQ;
  localparam logic [2:0] S_MAC_WAIT = MAC_WAIT;
  localparam logic [2:0] S_STORE    = STORE;
  localparam logic [2:0] S_DONE     = DONE;

  // Job configuration as seen from the CSR block.
  typedef struct packed {
    logic [ADDR_W-1:0] in_base;
    logic [ADDR_W-1:0] out_base;
    logic [CNT_W-1:0]  num_vectors;
  } sched_cfg_t;

  // Number of bus words needed to carry a packed vector of total_bits.
  function automatic int unsigned bus_words(input int unsigned total_bits,
                                            input int unsigned bus_bits);
    return total_bits / bus_bits;
  endfunction

endpackage

// File: rtl/qracc_word_packer.sv
// Assembles consecutive buffer words into the wide MAC input vector.
// Word k of a load lands in vec[k*wordBits +: wordBits]; the index counter
// is held at zero while clear is asserted.
module qracc_word_packer #(
  parameter int unsigned wordBits = 32,
  parameter int unsigned numWords = 16,
  parameter int unsigned idxWidth = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         capture,
  input  logic [wordBits-1:0]          word,
  output logic [wordBits*numWords-1:0] vec,
  output logic [idxWidth-1:0]          word_idx
);

  // Write the incoming word into its slot and advance the word index.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec      <= '0;
      word_idx <= '0;
    end else if (clear) begin
      word_idx <= '0;
    end else if (capture) begin
      for (int unsigned k = 0; k < numWords; k++) begin
        if (word_idx == idxWidth'(k)) begin
          vec[k*wordBits +: wordBits] <= word;
        end
      end
      word_idx <= word_idx + 1'b1;
    end
  end

endmodule

// File: rtl/qracc_scheduler.sv
// Layer sequencer for the QRAcc core: streams input vectors from the
// activation buffer into seq_acc, captures each result and writes it back,
// repeating for the programmed number of vectors.
module qracc_scheduler
  import qracc_pkg::*;
#(
  parameter int unsigned inputBits      = 4,
  parameter int unsigned inputElements  = 128,
  parameter int unsigned outputBits     = 8,
  parameter int unsigned outputElements = 32,
  parameter int unsigned bufWidth       = 32,
  parameter int unsigned addrWidth      = 32,
  parameter int unsigned countWidth     = 16
) (
  input  logic                                    clk,
  input  logic                                    nrst,
  input  logic                                    start_i,
  input  logic [addrWidth-1:0]                    in_base_addr_i,
  input  logic [addrWidth-1:0]                    out_base_addr_i,
  input  logic [countWidth-1:0]                   num_vectors_i,
  output logic                                    busy_o,
  output logic                                    done_o,
  output logic [countWidth-1:0]                   vec_count_o,
  output logic                                    buf_rd_en_o,
  output logic [addrWidth-1:0]                    buf_rd_addr_o,
  input  logic [bufWidth-1:0]                     buf_rd_data_i,
  output logic                                    buf_wr_en_o,
  output logic [addrWidth-1:0]                    buf_wr_addr_o,
  output logic [bufWidth-1:0]                     buf_wr_data_o,
  output logic [inputElements*inputBits-1:0]      mac_data_o,
  output logic                                    mac_valid_o,
  input  logic                                    mac_ready_i,
  input  logic                                    mac_result_valid_i,
  input  logic [outputElements*outputBits-1:0]    mac_result_i
);

  localparam int unsigned VEC_W     = inputElements * inputBits;
  localparam int unsigned RES_W     = outputElements * outputBits;
  localparam int unsigned IN_WORDS  = bus_words(VEC_W, bufWidth);
  localparam int unsigned OUT_WORDS = bus_words(RES_W, bufWidth);
  localparam int unsigned ADDR_STEP = bufWidth / 8;
  localparam int unsigned LCW       = $clog2(IN_WORDS + 1);
  localparam int unsigned SCW       = $clog2(OUT_WORDS + 1);

  localparam logic [addrWidth-1:0] STEP       = addrWidth'(ADDR_STEP);
  localparam logic [addrWidth-1:0] IN_STRIDE  = addrWidth'(IN_WORDS * ADDR_STEP);
  localparam logic [addrWidth-1:0] OUT_STRIDE = addrWidth'(OUT_WORDS * ADDR_STEP);

  if ((VEC_W % bufWidth) != 0) begin : g_in_width_chk
    $error("qracc_scheduler: input vector width is not a multiple of bufWidth");
  end
  if ((RES_W % bufWidth) != 0) begin : g_out_width_chk
    $error("qracc_scheduler: result width is not a multiple of bufWidth");
  end

  logic [2:0]            state;
  logic [addrWidth-1:0]  in_ptr;
  logic [addrWidth-1:0]  out_ptr;
  logic [countWidth-1:0] num_vec;
  logic [countWidth-1:0] vec_count;
  logic [countWidth-1:0] count_next;
  logic [LCW-1:0]        load_cnt;
  logic [SCW-1:0]        store_cnt;
  logic                  cap_pending;
  logic [RES_W-1:0]      result_q;
  logic [LCW-1:0]        word_idx;
  logic                  rd_issue;
  logic                  wr_issue;
  logic                  last_capture;
  logic [bufWidth-1:0]   wr_word;

  // Reads go out on the first IN_WORDS cycles of LOAD; the extra cycle
  // only collects the trailing data word.
  assign rd_issue     = (state == S_LOAD) && (load_cnt < LCW'(IN_WORDS));
  assign wr_issue     = (state == S_STORE);
  assign last_capture = cap_pending && (word_idx == LCW'(IN_WORDS - 1));
  assign count_next   = vec_count + 1'b1;

  qracc_word_packer #(
    .wordBits (bufWidth),
    .numWords (IN_WORDS),
    .idxWidth (LCW)
  ) u_packer (
    .clk      (clk),
    .rst      (nrst),
    .clear    (state != S_LOAD),
    .capture  (cap_pending),
    .word     (buf_rd_data_i),
    .vec      (mac_data_o),
    .word_idx (word_idx)
  );

  // Sequencer state, job pointers, per-phase counters and result capture.
  always_ff @(posedge clk) begin
    if (nrst) begin
      state       <= S_IDLE;
      in_ptr      <= '0;
      out_ptr     <= '0;
      num_vec     <= '0;
      vec_count   <= '0;
      load_cnt    <= '0;
      store_cnt   <= '0;
      cap_pending <= 1'b0;
      result_q    <= '0;
    end else begin
      cap_pending <= rd_issue;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            in_ptr    <= in_base_addr_i;
            out_ptr   <= out_base_addr_i;
            num_vec   <= num_vectors_i;
            vec_count <= '0;
            load_cnt  <= '0;
            store_cnt <= '0;
            state     <= (num_vectors_i == '0) ? S_DONE : S_LOAD;
          end
        end
        S_LOAD: begin
          if (rd_issue) begin
            load_cnt <= load_cnt + 1'b1;
          end
          if (last_capture) begin
            load_cnt <= '0;
            state    <= S_MAC_REQ;
          end
        end
        S_MAC_REQ: begin
          if (mac_ready_i) begin
            state <= S_MAC_WAIT;
          end
        end
        S_MAC_WAIT: begin
          if (mac_result_valid_i) begin
            result_q  <= mac_result_i;
            store_cnt <= '0;
            state     <= S_STORE;
          end
        end
        S_STORE: begin
          if (store_cnt == SCW'(OUT_WORDS - 1)) begin
            store_cnt <= '0;
            vec_count <= count_next;
            in_ptr    <= in_ptr + IN_STRIDE;
            out_ptr   <= out_ptr + OUT_STRIDE;
            state     <= (count_next == num_vec) ? S_DONE : S_LOAD;
          end else begin
            store_cnt <= store_cnt + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Select the result word for the current store beat.
  always_comb begin
    wr_word = '0;
    for (int unsigned k = 0; k < OUT_WORDS; k++) begin
      if (store_cnt == SCW'(k)) begin
        wr_word = result_q[k*bufWidth +: bufWidth];
      end
    end
  end

  // Strobes are masked by reset combinationally so that the cycle in which
  // reset is sampled never issues a buffer access.
  assign buf_rd_en_o   = rd_issue && !nrst;
  assign buf_rd_addr_o = buf_rd_en_o ? (in_ptr + addrWidth'(load_cnt) * STEP) : '0;
  assign buf_wr_en_o   = wr_issue && !nrst;
  assign buf_wr_addr_o = buf_wr_en_o ? (out_ptr + addrWidth'(store_cnt) * STEP) : '0;
  assign buf_wr_data_o = buf_wr_en_o ? wr_word : '0;

  assign mac_valid_o = (state == S_MAC_REQ);
  assign busy_o      = (state != S_IDLE);
  assign done_o      = (state == S_DONE);
  assign vec_count_o = vec_count;

endmodule

// File: tb/tb_qracc_scheduler.sv
// Self-checking bench for qracc_scheduler: buffer and seq_acc responders,
// a queue-based model of the expected bus traffic, and directed jobs.
module tb_qracc_scheduler;

  localparam int unsigned AW   = 32;
  localparam int unsigned CW   = 16;
  localparam int unsigned BW   = 32;
  localparam int unsigned VW   = 512;
  localparam int unsigned RW   = 256;
  localparam int unsigned INW  = 16;
  localparam int unsigned OUTW = 8;

  logic          clk = 1'b0;
  logic          nrst;
  logic          start_i;
  logic [AW-1:0] in_base_addr_i;
  logic [AW-1:0] out_base_addr_i;
  logic [CW-1:0] num_vectors_i;
  logic          busy_o;
  logic          done_o;
  logic [CW-1:0] vec_count_o;
  logic          buf_rd_en_o;
  logic [AW-1:0] buf_rd_addr_o;
  logic [BW-1:0] buf_rd_data_i;
  logic          buf_wr_en_o;
  logic [AW-1:0] buf_wr_addr_o;
  logic [BW-1:0] buf_wr_data_o;
  logic [VW-1:0] mac_data_o;
  logic          mac_valid_o;
  logic          mac_ready_i;
  logic          mac_result_valid_i;
  logic [RW-1:0] mac_result_i;

  always #5 clk = ~clk;

  qracc_scheduler #(
    .inputBits      (4),
    .inputElements  (128),
    .outputBits     (8),
    .outputElements (32),
    .bufWidth       (32),
    .addrWidth      (32),
    .countWidth     (16)
  ) dut (
    .clk                (clk),
    .nrst               (nrst),
    .start_i            (start_i),
    .in_base_addr_i     (in_base_addr_i),
    .out_base_addr_i    (out_base_addr_i),
    .num_vectors_i      (num_vectors_i),
    .busy_o             (busy_o),
    .done_o             (done_o),
    .vec_count_o        (vec_count_o),
    .buf_rd_en_o        (buf_rd_en_o),
    .buf_rd_addr_o      (buf_rd_addr_o),
    .buf_rd_data_i      (buf_rd_data_i),
    .buf_wr_en_o        (buf_wr_en_o),
    .buf_wr_addr_o      (buf_wr_addr_o),
    .buf_wr_data_o      (buf_wr_data_o),
    .mac_data_o         (mac_data_o),
    .mac_valid_o        (mac_valid_o),
    .mac_ready_i        (mac_ready_i),
    .mac_result_valid_i (mac_result_valid_i),
    .mac_result_i       (mac_result_i)
  );

  int errors = 0;
  int checks = 0;

  // Expected traffic, built from the job parameters alone.
  logic [AW-1:0] exp_rd[$];
  logic [AW-1:0] exp_wr_addr[$];
  logic [BW-1:0] exp_wr_data[$];
  logic [VW-1:0] exp_vec[$];
  // Observed traffic, for literal address checks.
  logic [AW-1:0] rd_log[$];
  logic [AW-1:0] wr_log[$];
  int            done_cnt = 0;

  int            cfg_ready_low = 0;
  int            cfg_lat = 3;
  bit            cfg_spur = 1'b0;
  bit            spur_sent = 1'b0;
  logic [VW-1:0] hs_vec;

  function automatic logic [BW-1:0] mem_word(input logic [AW-1:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [RW-1:0] mac_fn(input logic [VW-1:0] v);
    logic [RW-1:0] r;
    r = '0;
    for (int k = 0; k < OUTW; k++) begin
      r[k*32 +: 32] = v[k*32 +: 32] ^ v[(k+8)*32 +: 32] ^ (32'h01010101 * 32'(k));
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic plan_job(input logic [AW-1:0] ib, input logic [AW-1:0] ob, input int n);
    logic [VW-1:0] vec;
    logic [RW-1:0] res;
    logic [AW-1:0] a;
    for (int v = 0; v < n; v++) begin
      vec = '0;
      for (int k = 0; k < INW; k++) begin
        a = ib + 32'((v*INW + k) * 4);
        exp_rd.push_back(a);
        vec[k*32 +: 32] = mem_word(a);
      end
      exp_vec.push_back(vec);
      res = mac_fn(vec);
      for (int k = 0; k < OUTW; k++) begin
        exp_wr_addr.push_back(ob + 32'((v*OUTW + k) * 4));
        exp_wr_data.push_back(res[k*32 +: 32]);
      end
    end
  endtask

  // Buffer and seq_acc responder; all inputs change on the falling edge.
  initial begin
    logic          pend;
    logic [AW-1:0] pend_addr;
    int            lat_cnt;
    int            low_cnt;
    pend = 1'b0; pend_addr = '0; lat_cnt = 0; low_cnt = 0;
    mac_ready_i = 1'b1; mac_result_valid_i = 1'b0; mac_result_i = '0;
    buf_rd_data_i = '0; hs_vec = '0;
    forever begin
      @(negedge clk);
      mac_result_valid_i = 1'b0;
      if (nrst) begin
        pend = 1'b0; lat_cnt = 0; low_cnt = 0;
        mac_ready_i = (cfg_ready_low == 0);
        buf_rd_data_i = 32'hBAD0BAD0;
      end else begin
        buf_rd_data_i = pend ? mem_word(pend_addr) : 32'hBAD0BAD0;
        pend = buf_rd_en_o;
        pend_addr = buf_rd_addr_o;
        if (lat_cnt > 0) begin
          lat_cnt--;
          if (lat_cnt == 0) begin
            mac_result_valid_i = 1'b1;
            mac_result_i = mac_fn(hs_vec);
          end
        end else if (cfg_spur && !spur_sent && buf_rd_en_o) begin
          mac_result_valid_i = 1'b1;
          mac_result_i = {8{32'hDEADBEEF}};
          spur_sent = 1'b1;
        end
        if (mac_valid_o) begin
          if (low_cnt < cfg_ready_low) begin
            mac_ready_i = 1'b0;
            low_cnt++;
          end else begin
            mac_ready_i = 1'b1;
          end
        end else begin
          mac_ready_i = (cfg_ready_low == 0);
          low_cnt = 0;
        end
        if (mac_valid_o && mac_ready_i) begin
          hs_vec = mac_data_o;
          lat_cnt = cfg_lat;
        end
      end
    end
  end

  // Compare process: every cycle, DUT traffic against the expected queues.
  initial begin
    logic          held_v;
    logic [VW-1:0] held;
    held_v = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      #1;
      if (nrst) begin
        held_v = 1'b0;
        check("wr_during_reset", buf_wr_en_o, 0);
      end else begin
        check("rd_wr_exclusive", buf_rd_en_o & buf_wr_en_o, 0);
        if (buf_rd_en_o) begin
          rd_log.push_back(buf_rd_addr_o);
          if (exp_rd.size() == 0) check("rd_unexpected", 1, 0);
          else check("rd_addr", buf_rd_addr_o, exp_rd.pop_front());
        end
        if (buf_wr_en_o) begin
          wr_log.push_back(buf_wr_addr_o);
          if (exp_wr_addr.size() == 0) check("wr_unexpected", 1, 0);
          else begin
            check("wr_addr", buf_wr_addr_o, exp_wr_addr.pop_front());
            check("wr_data", buf_wr_data_o, exp_wr_data.pop_front());
          end
        end
        if (mac_valid_o) begin
          if (held_v) check("mac_data_stable", mac_data_o, held);
          if (mac_ready_i) begin
            if (exp_vec.size() == 0) check("mac_unexpected", 1, 0);
            else check("mac_data", mac_data_o, exp_vec.pop_front());
            held_v = 1'b0;
          end else begin
            held_v = 1'b1;
            held = mac_data_o;
          end
        end else begin
          held_v = 1'b0;
        end
        if (done_o) begin
          done_cnt++;
          check("busy_in_done", busy_o, 1);
        end
      end
    end
  end

  // Called at a point away from the clock edge.
  task automatic start_job(input logic [AW-1:0] ib, input logic [AW-1:0] ob, input int n,
                           input int rl, input int lat, input bit spur);
    plan_job(ib, ob, n);
    cfg_ready_low = rl; cfg_lat = lat; cfg_spur = spur; spur_sent = 1'b0;
    rd_log.delete(); wr_log.delete(); done_cnt = 0;
    in_base_addr_i = ib; out_base_addr_i = ob; num_vectors_i = 16'(n);
    start_i = 1'b1;
  endtask

  task automatic wait_done(input int budget, input bit hold, output int cyc);
    bit got;
    got = 1'b0;
    cyc = 0;
    for (int i = 1; i <= budget && !got; i++) begin
      @(negedge clk);
      if (!hold) start_i = 1'b0;
      #2;
      if (done_o) begin
        got = 1'b1;
        cyc = i;
      end
    end
    check("done_seen", got, 1);
  endtask

  task automatic finish_job(input int n);
    @(negedge clk);
    start_i = 1'b0;
    #2;
    check("done_pulse_width", done_o, 0);
    check("idle_after_done", busy_o, 0);
    check("vec_count", vec_count_o, n);
    repeat (3) @(negedge clk);
    #2;
    check("still_idle", busy_o, 0);
    check("vec_count_hold", vec_count_o, n);
    check("done_pulses", done_cnt, 1);
    check("rd_left", exp_rd.size(), 0);
    check("wr_left", exp_wr_addr.size(), 0);
    check("vec_left", exp_vec.size(), 0);
  endtask

  initial begin
    int cyc;
    bit hit;
    nrst = 1'b1; start_i = 1'b0;
    in_base_addr_i = '0; out_base_addr_i = '0; num_vectors_i = '0;
    repeat (3) @(negedge clk);
    #2;
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_count", vec_count_o, 0);
    check("rst_valid", mac_valid_o, 0);
    check("rst_mac_data", mac_data_o, 0);
    check("rst_rd_en", buf_rd_en_o, 0);
    check("rst_wr_en", buf_wr_en_o, 0);
    @(negedge clk);
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    #2;

    // 1: single vector, ready tied high, result 3 cycles after handshake.
    start_job(32'h0, 32'h100, 1, 0, 3, 1'b0);
    wait_done(200, 1'b0, cyc);
    check("t1_latency", cyc, 30);
    check("t1_rd_count", rd_log.size(), 16);
    check("t1_rd_first", rd_log[0], 32'h0);
    check("t1_rd_last", rd_log[15], 32'h3C);
    check("t1_wr_count", wr_log.size(), 8);
    check("t1_wr_first", wr_log[0], 32'h100);
    check("t1_wr_last", wr_log[7], 32'h11C);
    finish_job(1);

    // 2: three vectors, ready held low 5 cycles per request.
    start_job(32'h0, 32'h100, 3, 5, 3, 1'b0);
    wait_done(400, 1'b0, cyc);
    check("t2_rd_count", rd_log.size(), 48);
    check("t2_rd_vec1", rd_log[16], 32'h40);
    check("t2_wr_count", wr_log.size(), 24);
    check("t2_wr_vec1", wr_log[8], 32'h120);
    finish_job(3);

    // 3: zero-length job.
    start_job(32'h500, 32'h600, 0, 0, 3, 1'b0);
    wait_done(20, 1'b0, cyc);
    check("t3_latency", cyc, 1);
    check("t3_rd_count", rd_log.size(), 0);
    check("t3_wr_count", wr_log.size(), 0);
    finish_job(0);

    // 4: spurious result pulse during LOAD must be ignored.
    start_job(32'h2000, 32'h3000, 2, 1, 2, 1'b1);
    wait_done(300, 1'b0, cyc);
    check("t4_spur_sent", spur_sent, 1);
    finish_job(2);

    // 5: reset while STORE is on word 4, then a clean job.
    start_job(32'h1000, 32'h2000, 2, 0, 2, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      start_i = 1'b0;
      #2;
      if (wr_log.size() == 4) hit = 1'b1;
    end
    check("t5_store_reached", hit, 1);
    @(negedge clk);
    nrst = 1'b1;
    #2;
    check("t5_wr_masked", buf_wr_en_o, 0);
    exp_rd.delete(); exp_wr_addr.delete(); exp_wr_data.delete(); exp_vec.delete();
    @(negedge clk);
    nrst = 1'b0;
    #2;
    check("t5_busy", busy_o, 0);
    check("t5_done", done_o, 0);
    check("t5_count", vec_count_o, 0);
    check("t5_valid", mac_valid_o, 0);
    check("t5_mac_data", mac_data_o, 0);
    check("t5_rd_en", buf_rd_en_o, 0);
    check("t5_wr_en", buf_wr_en_o, 0);
    check("t5_rd_addr", buf_rd_addr_o, 0);
    check("t5_wr_addr", buf_wr_addr_o, 0);
    check("t5_wr_data", buf_wr_data_o, 0);
    repeat (3) @(negedge clk);
    #2;
    check("t5_writes_total", wr_log.size(), 4);
    start_job(32'h0, 32'h100, 1, 0, 3, 1'b0);
    wait_done(200, 1'b0, cyc);
    check("t5_rerun_rd_first", rd_log[0], 32'h0);
    check("t5_rerun_wr_first", wr_log[0], 32'h100);
    finish_job(1);

    // 6: read address wrap, start held high through DONE.
    start_job(32'hFFFFFFF0, 32'h40, 1, 0, 3, 1'b0);
    wait_done(200, 1'b1, cyc);
    check("t6_rd_pre_wrap", rd_log[3], 32'hFFFFFFFC);
    check("t6_rd_wrap", rd_log[4], 32'h0);
    check("t6_rd_last", rd_log[15], 32'h2C);
    finish_job(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
